// File: rtl/wave_gen.sv
// wave_gen: phase-accumulator test-waveform source (square, sawtooth,
// triangle, DC) with amplitude scaling, shadowed configuration and a
// valid/ready output stream that never withdraws an unaccepted sample.
module wave_gen #(
    parameter int DATA_W  = 8,
    parameter int PHASE_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [1:0]         cfg_mode,
    input  logic [PHASE_W-1:0] cfg_step,
    input  logic [DATA_W-1:0]  cfg_amp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_sync
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [1:0]         mode;
        logic [PHASE_W-1:0] step;
        logic [DATA_W-1:0]  amp;
    } cfg_t;

    state_t             state_q, state_n;
    logic [PHASE_W-1:0] phase_q, phase_n;
    cfg_t               act_q, act_n;
    cfg_t               pend_q, pend_n;
    logic               pflag_q, pflag_n;
    logic               valid_n, sync_n;
    logic [DATA_W-1:0]  data_n;

    // Raw waveform for a phase, then scaled by (amp+1)/2^DATA_W.
    function automatic logic [DATA_W-1:0] shape(input logic [1:0]         mode,
                                                input logic [PHASE_W-1:0] ph,
                                                input logic [DATA_W-1:0]  amp);
        logic [DATA_W-1:0]   r;
        logic [DATA_W-1:0]   p;
        logic [DATA_W:0]     amp1;
        logic [2*DATA_W:0]   prod;
        p = ph[PHASE_W-2 -: DATA_W];
        case (mode)
            2'd0:    r = ph[PHASE_W-1] ? '0 : '1;
            2'd1:    r = ph[PHASE_W-1 -: DATA_W];
            2'd2:    r = ph[PHASE_W-1] ? ~p : p;
            default: r = '1;
        endcase
        amp1 = {1'b0, amp} + {{DATA_W{1'b0}}, 1'b1};
        prod = {{(DATA_W+1){1'b0}}, r} * {{DATA_W{1'b0}}, amp1};
        return prod[2*DATA_W-1 -: DATA_W];
    endfunction

    logic [PHASE_W:0] sum;
    logic             apply;
    cfg_t             eff;

    // Next-state, phase advance, config shadowing and next output sample.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_n = state_q;
        phase_n = phase_q;
        act_n   = act_q;
        pend_n  = pend_q;
        pflag_n = pflag_q;
        valid_n = out_valid;
        data_n  = out_data;
        sync_n  = out_sync;
        apply   = 1'b0;
        eff     = act_q;
        sum     = {1'b0, phase_q} + {1'b0, act_q.step};

        case (state_q)
            IDLE: begin
                // Pending config lands on the first idle edge after a load.
                apply = pflag_q;
                eff   = pflag_q ? pend_q : act_q;
                act_n = eff;
                if (en) begin
                    state_n = RUN;
                    valid_n = 1'b1;
                    phase_n = '0;
                    data_n  = shape(eff.mode, '0, eff.amp);
                    sync_n  = 1'b1;
                end
            end
            RUN: begin
                if (out_valid && out_ready) begin
                    if (en) begin
                        // The add uses the old step; a wrap swaps in pending
                        // mode/amp for the sample produced at this very edge.
                        apply   = sum[PHASE_W] && pflag_q;
                        eff     = apply ? pend_q : act_q;
                        act_n   = eff;
                        phase_n = sum[PHASE_W-1:0];
                        data_n  = shape(eff.mode, sum[PHASE_W-1:0], eff.amp);
                        sync_n  = sum[PHASE_W];
                    end else begin
                        state_n = IDLE;
                        valid_n = 1'b0;
                        phase_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // A coincident load wins over the clear: old pending applied, new captured.
        if (cfg_load) begin
            pend_n  = '{mode: cfg_mode, step: cfg_step, amp: cfg_amp};
            pflag_n = 1'b1;
        end else if (apply) begin
            pflag_n = 1'b0;
        end
    end

    // State, phase, config and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            phase_q   <= '0;
            act_q     <= '0;
            pend_q    <= '0;
            pflag_q   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sync  <= 1'b0;
        end else begin
            state_q   <= state_n;
            phase_q   <= phase_n;
            act_q     <= act_n;
            pend_q    <= pend_n;
            pflag_q   <= pflag_n;
            out_valid <= valid_n;
            out_data  <= data_n;
            out_sync  <= sync_n;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// tb_wave_gen: directed scenarios plus randomized traffic for wave_gen,
// checked every cycle against an arithmetic reference model.
module tb_wave_gen;

    localparam int    DW     = 8;
    localparam int    PW     = 24;
    localparam longint PH_MOD = longint'(1) << PW;
    localparam longint HALF   = PH_MOD / 2;
    localparam longint SAW_DV = longint'(1) << (PW - DW);
    localparam longint TRI_DV = longint'(1) << (PW - 1 - DW);
    localparam int    MAXV   = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          cfg_load = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [PW-1:0] cfg_step = '0;
    logic [DW-1:0] cfg_amp = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_sync;

    wave_gen #(.DATA_W(DW), .PHASE_W(PW)) dut (
        .clk(clk), .rst(rst), .en(en), .cfg_load(cfg_load),
        .cfg_mode(cfg_mode), .cfg_step(cfg_step), .cfg_amp(cfg_amp),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sync(out_sync)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Output value straight from the waveform definitions.
    function automatic int wave(input int mode, input longint ph, input int amp);
        int r;
        int p;
        case (mode)
            0: r = (ph < HALF) ? MAXV : 0;
            1: r = int'(ph / SAW_DV);
            2: begin
                p = int'((ph % HALF) / TRI_DV);
                r = (ph < HALF) ? p : MAXV - p;
            end
            default: r = MAXV;
        endcase
        return (r * (amp + 1)) / (MAXV + 1);
    endfunction

    typedef struct { int data; bit sync; } samp_t;
    samp_t acc[$];

    // Reference model state.
    int     m_mode = 0, m_amp = 0, p_mode = 0, p_amp = 0, m_data = 0;
    longint m_step = 0, p_step = 0, m_phase = 0;
    bit     p_flag = 0, m_run = 0, m_valid = 0, m_sync = 0;
    bit     d_valid = 0, d_sync = 0;
    int     d_data = 0;

    // Advance model on each edge, log accepted samples, then compare.
    always @(posedge clk) begin : model
        longint sum;
        bit     wrap;
        bit     apply;
        if (d_valid && out_ready && !rst)
            acc.push_back('{data: d_data, sync: d_sync});
        if (rst) begin
            m_mode = 0; m_amp = 0; m_step = 0;
            p_mode = 0; p_amp = 0; p_step = 0; p_flag = 0;
            m_run = 0; m_valid = 0; m_phase = 0; m_data = 0; m_sync = 0;
        end else begin
            apply = 0;
            if (!m_run) begin
                if (p_flag) begin
                    apply = 1;
                    m_mode = p_mode; m_amp = p_amp; m_step = p_step;
                end
                if (en) begin
                    m_run = 1; m_valid = 1; m_phase = 0; m_sync = 1;
                    m_data = wave(m_mode, 0, m_amp);
                end
            end else if (m_valid && out_ready) begin
                if (en) begin
                    sum     = m_phase + m_step;
                    wrap    = (sum >= PH_MOD);
                    m_phase = sum % PH_MOD;
                    if (wrap && p_flag) begin
                        apply = 1;
                        m_mode = p_mode; m_amp = p_amp; m_step = p_step;
                    end
                    m_data = wave(m_mode, m_phase, m_amp);
                    m_sync = wrap;
                end else begin
                    m_run = 0; m_valid = 0; m_phase = 0;
                end
            end
            if (cfg_load) begin
                p_mode = int'(cfg_mode); p_step = longint'(cfg_step); p_amp = int'(cfg_amp);
                p_flag = 1;
            end else if (apply) begin
                p_flag = 0;
            end
        end
        #1;
        check("valid", out_valid, m_valid);
        if (m_valid) begin
            check("data", out_data, m_data);
            check("sync", out_sync, m_sync);
        end
        d_valid = out_valid;
        d_data  = int'(out_data);
        d_sync  = out_sync;
    end

    task automatic restart(input int mode, input int step, input int amp);
        @(negedge clk);
        en = 0;
        out_ready = 1;
        for (int i = 0; i < 20 && out_valid; i++) @(negedge clk);
        check("drain_to_idle", out_valid, 0);
        cfg_load = 1;
        cfg_mode = 2'(mode);
        cfg_step = PW'(step);
        cfg_amp  = DW'(amp);
        @(negedge clk);
        cfg_load = 0;
        @(negedge clk);
        acc.delete();
        en = 1;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < 5000 && acc.size() < n; i++) @(negedge clk);
        check("collect_enough", acc.size() >= n, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int breaks;
        logic [DW-1:0] held;

        repeat (3) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_sync", out_sync, 0);
        rst = 0;

        // Sawtooth ramp 0..255.
        restart(1, 'h010000, 'hFF);
        collect(258);
        if (acc.size() >= 258) begin
            breaks = 0;
            for (int i = 0; i < 258; i++) begin
                if (acc[i].data != (i % 256)) breaks++;
                if (acc[i].sync != (acc[i].data == 0)) breaks++;
            end
            check("saw_ramp_errors", breaks, 0);
            check("saw_first", acc[0].data, 0);
            check("saw_first_sync", acc[0].sync, 1);
            check("saw_last", acc[255].data, 255);
            check("saw_wrap_sync", acc[256].sync, 1);
        end

        // Triangle.
        restart(2, 'h020000, 'hFF);
        collect(130);
        if (acc.size() >= 130) begin
            check("tri_1", acc[1].data, 4);
            check("tri_63", acc[63].data, 252);
            check("tri_64", acc[64].data, 255);
            check("tri_65", acc[65].data, 251);
            check("tri_127", acc[127].data, 3);
            check("tri_128", acc[128].data, 0);
            check("tri_128_sync", acc[128].sync, 1);
        end

        // Square at half amplitude, then DC loaded mid-period.
        restart(0, 'h400000, 'h7F);
        collect(6);
        cfg_load = 1; cfg_mode = 2'd3; cfg_step = PW'('h400000); cfg_amp = 8'h3F;
        @(negedge clk);
        cfg_load = 0;
        collect(12);
        if (acc.size() >= 12) begin
            check("sq_0", acc[0].data, 127);
            check("sq_1", acc[1].data, 127);
            check("sq_2", acc[2].data, 0);
            check("sq_3", acc[3].data, 0);
            check("sq_4_sync", acc[4].sync, 1);
            check("sq_7_old", acc[7].data, 0);
            check("dc_at_sync", acc[8].data, 63);
            check("dc_sync_flag", acc[8].sync, 1);
            check("dc_after", acc[11].data, 63);
        end

        // Sawtooth under random backpressure.
        restart(1, 'h010000, 'hFF);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        out_ready = 1;
        breaks = 0;
        for (int i = 1; i < acc.size(); i++)
            if (acc[i].data != (acc[i-1].data + 1) % 256) breaks++;
        check("bp_consecutive_breaks", breaks, 0);
        check("bp_enough", acc.size() >= 100, 1);
        if (acc.size() > 0) check("bp_start", acc[0].data, 0);

        // en drop while stalled.
        @(negedge clk);
        out_ready = 0;
        @(negedge clk);
        en = 0;
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, held);
        end
        out_ready = 1;
        acc.delete();
        @(negedge clk);
        check("drop_valid", out_valid, 0);
        check("drop_count", acc.size(), 1);
        if (acc.size() == 1) check("drop_value", acc[0].data, held);
        en = 1;
        @(negedge clk);
        check("reen_valid", out_valid, 1);
        check("reen_data", out_data, 0);
        check("reen_sync", out_sync, 1);

        // Reset mid-stream with a pending load and the sink stalled.
        repeat (5) @(negedge clk);
        cfg_load = 1; cfg_mode = 2'd3; cfg_step = '0; cfg_amp = 8'h3F;
        @(negedge clk);
        cfg_load = 0;
        out_ready = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("mrst_valid", out_valid, 0);
        check("mrst_data", out_data, 0);
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_valid", out_valid, 1);
            check("post_rst_data", out_data, 0);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            en        = ($urandom_range(0, 15) != 0);
            rst       = ($urandom_range(0, 499) == 0);
            cfg_load  = ($urandom_range(0, 19) == 0);
            cfg_mode  = 2'($urandom_range(0, 3));
            cfg_amp   = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 3))
                0:       cfg_step = '0;
                1:       cfg_step = PW'($urandom_range(1, 255) << 14);
                2:       cfg_step = PW'($urandom_range(1, 'hFFFFFF));
                default: cfg_step = PW'('h400000);
            endcase
        end
        @(negedge clk);
        rst = 0; cfg_load = 0; en = 0; out_ready = 1;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
